// File: rtl/tag_verify.sv
// Constant-time ASCON-128 tag checker; optional idle timeout under TAG_VERIFY_TIMEOUT_EN.
// Latency: verdict one cycle after the 4th accepted word (5 cycles minimum from start).
// Backpressure: word_ready only in RECV; valid gaps stall the check (bounded only with timeout).
module tag_verify #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         clear_i,
    input  logic         start_i,
    input  logic [127:0] tag_i,
    input  logic         word_valid_i,
    input  logic [31:0]  word_i,
    output logic         word_ready_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         tag_ok_o,
    output logic         timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RECV = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] snap_q;
    logic [31:0]  acc_q;
    logic [1:0]   idx_q;
    logic         done_q, ok_q, tmo_q;
    logic [31:0]  snap_word;
    logic [31:0]  acc_nxt;
    logic         accept;
    logic         start_go;
    logic         tmo_hit;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("tag_verify: TIMEOUT_CYCLES out of range 1..255");
    end

    // Big-endian word order: idx 0 compares the most significant word.
    always_comb begin
        snap_word = snap_q[127:96];
        case (idx_q)
            2'd0: snap_word = snap_q[127:96];
            2'd1: snap_word = snap_q[95:64];
            2'd2: snap_word = snap_q[63:32];
            2'd3: snap_word = snap_q[31:0];
            default: snap_word = snap_q[127:96];
        endcase
    end

    assign accept   = (state_q == RECV) && word_valid_i;
    assign start_go = start_i && ((state_q == IDLE) || (state_q == DONE));
    assign acc_nxt  = acc_q | (word_i ^ snap_word);

`ifdef TAG_VERIFY_TIMEOUT_EN
    logic [7:0] idle_q;

    // Held at zero outside RECV, so it is already cleared on entry.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            idle_q <= 8'd0;
        end else if (clear_i || (state_q != RECV) || accept) begin
            idle_q <= 8'd0;
        end else begin
            idle_q <= idle_q + 8'd1;
        end
    end

    assign tmo_hit = (state_q == RECV) && !accept && (idle_q == 8'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        word_ready_o = 1'b0;
        busy_o       = 1'b0;
        case (state_q)
            IDLE: if (start_i) state_d = RECV;
            RECV: begin
                word_ready_o = 1'b1;
                busy_o       = 1'b1;
                if ((accept && (idx_q == 2'd3)) || tmo_hit) state_d = DONE;
            end
            DONE: if (start_i) state_d = RECV;
            default: state_d = IDLE;
        endcase
        if (clear_i) state_d = IDLE;
    end

    // No early exit: every word folds into acc regardless of earlier differences.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            snap_q <= '0;
            acc_q  <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
            ok_q   <= 1'b0;
            tmo_q  <= 1'b0;
        end else if (clear_i) begin
            snap_q <= '0;
            acc_q  <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
            ok_q   <= 1'b0;
            tmo_q  <= 1'b0;
        end else if (start_go) begin
            snap_q <= tag_i;
            acc_q  <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
            ok_q   <= 1'b0;
            tmo_q  <= 1'b0;
        end else if (accept) begin
            acc_q <= acc_nxt;
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                done_q <= 1'b1;
                ok_q   <= (acc_nxt == 32'd0);
            end
        end else if (tmo_hit) begin
            done_q <= 1'b1;
            ok_q   <= 1'b0;
            tmo_q  <= 1'b1;
        end
    end

    assign done_o    = done_q;
    assign tag_ok_o  = ok_q;
    assign timeout_o = tmo_q;

endmodule

// File: tb/tb_tag_verify.sv
// Directed bench for tag_verify; timeout case adapts to TAG_VERIFY_TIMEOUT_EN.
module tb_tag_verify;

    logic         clock_i = 1'b0;
    logic         resetb_i;
    logic         clear_i;
    logic         start_i;
    logic [127:0] tag_i;
    logic         word_valid_i;
    logic [31:0]  word_i;
    logic         word_ready_o;
    logic         busy_o;
    logic         done_o;
    logic         tag_ok_o;
    logic         timeout_o;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] TAG_A = 128'h000102030405060708090A0B0C0D0E0F;

    tag_verify #(.TIMEOUT_CYCLES(10)) dut (
        .clock_i      (clock_i),
        .resetb_i     (resetb_i),
        .clear_i      (clear_i),
        .start_i      (start_i),
        .tag_i        (tag_i),
        .word_valid_i (word_valid_i),
        .word_i       (word_i),
        .word_ready_o (word_ready_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .tag_ok_o     (tag_ok_o),
        .timeout_o    (timeout_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Start, then four back-to-back words; verdict must appear exactly 5 cycles after start.
    task automatic run_check(input string name, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3, input logic exp_ok);
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        do_start();
        chk({name, "_busy"}, 32'(busy_o), 32'd1);
        chk({name, "_ready"}, 32'(word_ready_o), 32'd1);
        chk({name, "_done_dropped"}, 32'(done_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            word_valid_i = 1'b1;
            word_i       = w[i];
            tick();
            if (i == 2) chk({name, "_done_early"}, 32'(done_o), 32'd0);
        end
        word_valid_i = 1'b0;
        chk({name, "_done"}, 32'(done_o), 32'd1);
        chk({name, "_ok"}, 32'(tag_ok_o), 32'(exp_ok));
        chk({name, "_busy_end"}, 32'(busy_o), 32'd0);
        chk({name, "_ready_end"}, 32'(word_ready_o), 32'd0);
        chk({name, "_timeout"}, 32'(timeout_o), 32'd0);
        tick();
        chk({name, "_done_hold"}, 32'(done_o), 32'd1);
        chk({name, "_ok_hold"}, 32'(tag_ok_o), 32'(exp_ok));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ready"}, 32'(word_ready_o), 32'd0);
        chk({name, "_busy"}, 32'(busy_o), 32'd0);
        chk({name, "_done"}, 32'(done_o), 32'd0);
        chk({name, "_ok"}, 32'(tag_ok_o), 32'd0);
        chk({name, "_timeout"}, 32'(timeout_o), 32'd0);
    endtask

    initial begin
        logic [6:0]  vpat;
        logic [31:0] bw [4];
        int          nacc;
        int          wi;

        resetb_i     = 1'b0;
        clear_i      = 1'b0;
        start_i      = 1'b0;
        tag_i        = TAG_A;
        word_valid_i = 1'b0;
        word_i       = '0;
        #12;
        chk_all_zero("reset");
        tick();
        resetb_i = 1'b1;
        tick();
        chk_all_zero("idle");

        run_check("match", 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F, 1'b1);
        run_check("last_bit", 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0E, 1'b0);
        run_check("word0", 32'h80010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F, 1'b0);

        // Backpressure with valid pattern 1-0-0-1-0-1-1 and tag_i altered after capture.
        bw[0] = 32'h00010203; bw[1] = 32'h04050607; bw[2] = 32'h08090A0B; bw[3] = 32'h0C0D0E0F;
        vpat = 7'b1101001;  // bit i = valid in cycle i
        do_start();
        tag_i = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
        nacc = 0;
        wi   = 0;
        for (int i = 0; i < 7; i++) begin
            word_valid_i = vpat[i];
            word_i       = (wi < 4) ? bw[wi] : 32'h0;
            if (word_valid_i && word_ready_o) begin
                nacc++;
                wi++;
            end
            tick();
            if (i == 5) chk("bp_done_early", 32'(done_o), 32'd0);
        end
        word_valid_i = 1'b0;
        chk("bp_accepts", 32'(nacc), 32'd4);
        chk("bp_done", 32'(done_o), 32'd1);
        chk("bp_ok", 32'(tag_ok_o), 32'd1);
        tag_i = TAG_A;

        // Clear from DONE drops the verdict.
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk_all_zero("clr_done");

        // Clear together with start and a word, after two accepts.
        do_start();
        word_valid_i = 1'b1;
        word_i = 32'h00010203; tick();
        word_i = 32'h04050607; tick();
        clear_i = 1'b1;
        start_i = 1'b1;
        word_i  = 32'h08090A0B;
        tick();
        clear_i = 1'b0;
        start_i = 1'b0;
        word_valid_i = 1'b0;
        chk_all_zero("clr_mid");
        tick();
        chk("clr_stays_idle", 32'(busy_o), 32'd0);

        // A clean check after the abort must start from fresh state.
        run_check("after_clr", 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F, 1'b1);

        // Asynchronous reset during RECV.
        do_start();
        word_valid_i = 1'b1;
        word_i = 32'h00010203;
        tick();
        word_valid_i = 1'b0;
        #2;
        resetb_i = 1'b0;
        #1;
        chk_all_zero("arst");
        tick();
        resetb_i = 1'b1;
        tick();
        chk("arst_idle", 32'(busy_o), 32'd0);

        // Timeout: two words then silence.
        do_start();
        word_valid_i = 1'b1;
        word_i = 32'h00010203; tick();
        word_i = 32'h04050607; tick();
        word_valid_i = 1'b0;
`ifdef TAG_VERIFY_TIMEOUT_EN
        for (int i = 0; i < 9; i++) tick();
        chk("tmo_done_early", 32'(done_o), 32'd0);
        tick();
        chk("tmo_done", 32'(done_o), 32'd1);
        chk("tmo_flag", 32'(timeout_o), 32'd1);
        chk("tmo_ok", 32'(tag_ok_o), 32'd0);
        chk("tmo_busy", 32'(busy_o), 32'd0);
        do_start();
        chk("tmo_cleared_by_start", 32'(timeout_o), 32'd0);
`else
        for (int i = 0; i < 20; i++) tick();
        chk("notmo_busy", 32'(busy_o), 32'd1);
        chk("notmo_ready", 32'(word_ready_o), 32'd1);
        chk("notmo_done", 32'(done_o), 32'd0);
        chk("notmo_flag", 32'(timeout_o), 32'd0);
`endif
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk_all_zero("final_clr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tag_verify.md
# tag_verify

Constant-time authentication-tag checker for the ASCON-128 decryption path. It sits directly downstream of the 128-bit tag register. On `start_i` it snapshots the computed tag, accepts the received tag as four 32-bit words over a valid/ready handshake, and compares every bit with no early exit. It then reports a single pass/fail verdict to the top-level controller, which gates plaintext release.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of idle cycles allowed between accepted words while receiving. Used only when the timeout feature is compiled in. Range 1..255.

Ports:
- `clock_i` in 1: single clock for the block; all logic is rising-edge.
- `resetb_i` in 1: reset, asynchronous and active-low.
- `clear_i` in 1: synchronous abort; returns the block to IDLE.
- `start_i` in 1: one-cycle pulse that starts a check.
- `tag_i` in 128: computed tag, taken from the tag register output.
- `word_valid_i` in 1: received tag word is valid.
- `word_i` in 32: received tag word.
- `word_ready_o` out 1: the block can accept a word this cycle.
- `busy_o` out 1: a check is in progress.
- `done_o` out 1: the verdict is valid; held until the next start or clear.
- `tag_ok_o` out 1: the tags matched. Meaningful only while `done_o` = 1.
- `timeout_o` out 1: the check ended on timeout.

## Operation
- States: IDLE, RECV, DONE. Encoding is 2-bit; the unused code recovers to IDLE.
- IDLE, on `start_i`:
  - Capture `tag_i` into an internal 128-bit snapshot.
  - Clear the 32-bit difference accumulator `acc` and the 2-bit word index `idx`.
  - Go to RECV.
- DONE, on `start_i`: same actions as IDLE.
- RECV:
  - `word_ready_o` = 1.
  - Each accept (`word_valid_i` & `word_ready_o`) updates `acc <= acc | (word_i ^ snap_word[idx])`, then `idx <= idx + 1`.
- Word order is big-endian: idx 0 compares `tag[127:96]`, idx 1 `tag[95:64]`, idx 2 `tag[63:32]`, idx 3 `tag[31:0]`.
- After the accept at idx 3, go to DONE. `idx` wraps to 0 and is unused afterwards.
- DONE:
  - `done_o` = 1.
  - `tag_ok_o` = (acc == 0) && !timeout.
- No early exit: all four words are always consumed, whatever the data values.
- `start_i` is ignored in RECV.
- `clear_i` in any state:
  - Go to IDLE, clear `acc`, `idx`, the snapshot and the verdict flags.
  - `clear_i` takes priority over `start_i` and over a word accept in the same cycle.
- `tag_i` changing after capture has no effect on the check in progress.

## Timing
- Reset values: `word_ready_o` = 0, `busy_o` = 0, `done_o` = 0, `tag_ok_o` = 0, `timeout_o` = 0. State is IDLE; snapshot, `acc` and `idx` are 0.
- `start_i` sampled at edge N gives `busy_o` = 1 and `word_ready_o` = 1 from cycle N+1.
- `word_ready_o` does not depend combinationally on `word_valid_i`.
- The fourth accept at edge M gives `done_o` = 1 and a valid `tag_ok_o` in cycle M+1. At the same time `busy_o` = 0 and `word_ready_o` = 0.
- Minimum check time is 5 cycles from start to verdict, with back-to-back words.
- Gaps in `word_valid_i` stall the check without limit, unless the timeout feature is compiled in.
- `done_o` and `tag_ok_o` stay stable in DONE. A `start_i` in DONE drops them in the next cycle.
- `resetb_i` asserted mid-check forces the reset values immediately, without waiting for a clock edge.
- Outputs are registered, except `word_ready_o` and `busy_o`, which decode directly from the state register.

## Configuration
- Macro: `TAG_VERIFY_TIMEOUT_EN`.
- Defined:
  - An 8-bit idle counter runs in RECV. It resets on every accept and on entry to RECV.
  - When the counter reaches `TIMEOUT_CYCLES` without an accept, the block goes to DONE with `timeout_o` = 1 and `tag_ok_o` = 0.
  - `timeout_o` clears on `start_i`, `clear_i` or reset.
- Undefined:
  - No counter is instantiated.
  - `timeout_o` is tied to 0 and `TIMEOUT_CYCLES` is ignored.
  - RECV waits indefinitely.

## Test plan
- Matching tag:
  - Stimulus: `tag_i` = 0x000102030405060708090A0B0C0D0E0F, start, then words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F back-to-back.
  - Required: `done_o` = 1 five cycles after start, `tag_ok_o` = 1.
- Single-bit mismatch in the last word:
  - Stimulus: same tag, last word 0x0C0D0E0E.
  - Required: `tag_ok_o` = 0, and `done_o` asserts in the same cycle as in the matching case.
- Mismatch in word 0 only:
  - Stimulus: first word 0x80010203.
  - Required: all 4 words still accepted, `tag_ok_o` = 0.
- Backpressure and stability:
  - Stimulus: `word_valid_i` toggled 1-0-0-1-0-1-1, and `tag_i` changed after start.
  - Required: exactly 4 accepts, verdict based on the captured tag, `done_o` one cycle after the 4th accept.
- Clear and reset mid-check:
  - Stimulus: `clear_i` asserted together with `start_i` and a word after 2 accepts.
  - Required: IDLE next cycle, all outputs 0.
  - Stimulus: `resetb_i` asserted low during RECV.
  - Required: outputs 0 immediately.
- Timeout (`TAG_VERIFY_TIMEOUT_EN` defined, `TIMEOUT_CYCLES` = 10):
  - Stimulus: 2 words, then no valid.
  - Required: `done_o` = 1, `timeout_o` = 1, `tag_ok_o` = 0 after 10 idle cycles.
  - Without the macro, the block stays in RECV and `timeout_o` stays 0.
